// File: rtl/montpro_seq.sv
// Sequencer for the bit-serial Montgomery datapath: accepts a, b and m, runs WID iterations, then reduces the result once.
// Latency: a legal request raises res_vld WID+2 edges after the accept edge. An illegal request has res_vld high in the next cycle.
// Backpressure: req_rdy is high only in IDLE. The result is held stable in DONE until res_rdy. abort cancels from any state.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   req_vld/req_rdy       request handshake carrying req_a, req_b, req_m
//   abort                 synchronous cancel; takes priority over every handshake
//   res_vld/res_rdy       result handshake carrying res_r and res_err (res_err = rejected request)
//   busy                  high whenever the sequencer is not idle
//   mp_a/mp_b/mp_m        operand registers that drive the datapath
//   mp_ldnew              datapath load/clear; low only while iterating
//   mp_r                  datapath accumulator, WID+1 bits wide
module montpro_seq #(
  parameter int WID = 256,
  parameter int CW  = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_vld,
  output logic           req_rdy,
  input  logic [WID-1:0] req_a,
  input  logic [WID-1:0] req_b,
  input  logic [WID-1:0] req_m,
  input  logic           abort,
  output logic           res_vld,
  input  logic           res_rdy,
  output logic [WID-1:0] res_r,
  output logic           res_err,
  output logic           busy,
  output logic [WID-1:0] mp_a,
  output logic [WID-1:0] mp_b,
  output logic [WID-1:0] mp_m,
  output logic           mp_ldnew,
  input  logic [WID:0]   mp_r
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [CW-1:0] LAST_ITER = CW'(WID - 1);

  state_t         state;
  logic [CW-1:0]  cnt;

  // The legality check uses the request inputs directly. A rejected set
  // therefore never reaches the operand registers.
  logic req_legal;
  assign req_legal = req_m[0] && (req_a < req_m) && (req_b < req_m);

  // Final conditional subtraction. The compare uses the full WID+1 bit
  // accumulator. The subtraction is done in WID bits because only the low WID
  // bits are kept. The result is the same as a WID+1 bit difference truncated
  // to WID bits.
  logic           fix_ge;
  logic [WID-1:0] fix_val;
  assign fix_ge  = (mp_r >= {1'b0, mp_m});
  assign fix_val = fix_ge ? (mp_r[WID-1:0] - mp_m) : mp_r[WID-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mp_a     <= '0;
      mp_b     <= '0;
      mp_m     <= '0;
      res_r    <= '0;
      res_vld  <= 1'b0;
      res_err  <= 1'b0;
      busy     <= 1'b0;
      mp_ldnew <= 1'b1;
      req_rdy  <= 1'b1;
    end else if (abort) begin
      // Cancel from any state. The operand registers keep their values.
      // The pending result is dropped, and the datapath is held in clear.
      state    <= IDLE;
      cnt      <= '0;
      res_r    <= '0;
      res_vld  <= 1'b0;
      res_err  <= 1'b0;
      busy     <= 1'b0;
      mp_ldnew <= 1'b1;
      req_rdy  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_vld) begin
            req_rdy <= 1'b0;
            busy    <= 1'b1;
            if (req_legal) begin
              mp_a  <= req_a;
              mp_b  <= req_b;
              mp_m  <= req_m;
              state <= LOAD;
            end else begin
              res_r   <= '0;
              res_err <= 1'b1;
              res_vld <= 1'b1;
              state   <= DONE;
            end
          end
        end

        LOAD: begin
          // The datapath loads the new operands this cycle (mp_ldnew is still
          // high). Iteration starts on the next edge.
          cnt      <= '0;
          mp_ldnew <= 1'b0;
          state    <= RUN;
        end

        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            mp_ldnew <= 1'b1;
            state    <= FIX;
          end
        end

        FIX: begin
          // mp_r holds the final accumulator only in this cycle.
          res_r   <= fix_val;
          res_err <= 1'b0;
          res_vld <= 1'b1;
          state   <= DONE;
        end

        DONE: begin
          if (res_rdy) begin
            res_vld <= 1'b0;
            res_err <= 1'b0;
            busy    <= 1'b0;
            req_rdy <= 1'b1;
            state   <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          cnt      <= '0;
          res_vld  <= 1'b0;
          res_err  <= 1'b0;
          busy     <= 1'b0;
          mp_ldnew <= 1'b1;
          req_rdy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montpro_seq.sv
// Bench for montpro_seq with WID=8. It includes a behavioural bit-serial datapath.
// Latency: the bench waits on DUT events with cycle bounds and has a global watchdog.
// Backpressure: the bench holds res_rdy low in one scenario to test result stability.
module tb_montpro_seq;
  localparam int WID = 8;
  localparam int CW  = 4;

  logic           clk;
  logic           rst;
  logic           req_vld;
  logic           req_rdy;
  logic [WID-1:0] req_a;
  logic [WID-1:0] req_b;
  logic [WID-1:0] req_m;
  logic           abort;
  logic           res_vld;
  logic           res_rdy;
  logic [WID-1:0] res_r;
  logic           res_err;
  logic           busy;
  logic [WID-1:0] mp_a;
  logic [WID-1:0] mp_b;
  logic [WID-1:0] mp_m;
  logic           mp_ldnew;
  logic [WID:0]   mp_r;

  int n_cmp = 0;
  int n_err = 0;

  montpro_seq #(.WID(WID), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_a(req_a), .req_b(req_b), .req_m(req_m),
    .abort(abort),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_r(res_r), .res_err(res_err),
    .busy(busy),
    .mp_a(mp_a), .mp_b(mp_b), .mp_m(mp_m),
    .mp_ldnew(mp_ldnew), .mp_r(mp_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath. mp_ldnew clears it. Each cycle with mp_ldnew low
  // consumes one bit of a, LSB first: acc = (acc + a_i*b [+ m]) / 2.
  logic [WID:0]   acc;
  logic [3:0]     bit_idx;
  logic [WID+1:0] acc_t;
  always @(posedge clk) begin
    if (mp_ldnew) begin
      acc     <= '0;
      bit_idx <= '0;
    end else begin
      acc_t = {1'b0, acc} + (mp_a[bit_idx[2:0]] ? {2'b00, mp_b} : '0);
      if (acc_t[0]) acc_t = acc_t + {2'b00, mp_m};
      acc     <= acc_t[WID+1:1];
      bit_idx <= bit_idx + 1'b1;
    end
  end
  assign mp_r = acc;

  // Reference: a*b*2^-WID mod m. The inverse of 2^WID is found by search.
  function automatic int mont_ref(input int a, input int b, input int m);
    int inv;
    inv = 0;
    for (int x = 0; x < m; x++)
      if (((x * (1 << WID)) % m) == 1) inv = x;
    return (((a * b) % m) * inv) % m;
  endfunction

  // Called at a negedge. Drives the request and waits for req_rdy.
  // Returns at the negedge that follows the accept edge.
  task automatic issue(input logic [WID-1:0] a, input logic [WID-1:0] b, input logic [WID-1:0] m);
    int n;
    req_a = a; req_b = b; req_m = m; req_vld = 1'b1;
    n = 0;
    while (!req_rdy && n < 50) begin @(negedge clk); n++; end
    n_cmp++;
    if (req_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL issue_rdy: req_rdy=%b required 1", req_rdy);
    end
    @(negedge clk);
    req_vld = 1'b0;
  endtask

  // Counts the edges after the accept edge until res_vld is seen high. It also
  // counts the cycles in which mp_ldnew was low.
  task automatic wait_res(output int edges, output int lows);
    edges = 0; lows = 0;
    while (res_vld !== 1'b1 && edges < 100) begin
      if (mp_ldnew === 1'b0) lows++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic ack();
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_vld = 1'b0; req_a = '0; req_b = '0; req_m = '0;
    abort = 1'b0; res_rdy = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req_rdy, res_vld, res_err, busy, mp_ldnew} !== 5'b10001) begin
      n_err++;
      $display("FAIL reset_ctrl: rdy/vld/err/busy/ldnew=%b required 10001",
               {req_rdy, res_vld, res_err, busy, mp_ldnew});
    end
    n_cmp++;
    if ({mp_a, mp_b, mp_m, res_r} !== '0) begin
      n_err++;
      $display("FAIL reset_regs: a=%0d b=%0d m=%0d r=%0d required all 0", mp_a, mp_b, mp_m, res_r);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int edges, lows;
    issue(8'd5, 8'd7, 8'd13);
    wait_res(edges, lows);
    n_cmp++;
    if (edges != WID + 2) begin n_err++; $display("FAIL basic_latency: got %0d required %0d", edges, WID + 2); end
    n_cmp++;
    if (lows != WID) begin n_err++; $display("FAIL basic_ldnew_low: got %0d required %0d", lows, WID); end
    n_cmp++;
    if (res_r !== 8'd1 || res_err !== 1'b0) begin
      n_err++; $display("FAIL basic_result: r=%0d err=%b required r=1 err=0", res_r, res_err);
    end
    ack();
  endtask

  task automatic test_m255();
    int edges, lows;
    issue(8'd254, 8'd254, 8'd255);
    wait_res(edges, lows);
    n_cmp++;
    if (res_r !== 8'd1 || res_err !== 1'b0) begin
      n_err++; $display("FAIL m255_result: r=%0d err=%b required r=1 err=0", res_r, res_err);
    end
    ack();
  endtask

  task automatic test_sweep13();
    int edges, lows, exp_r;
    for (int a = 0; a < 13; a++) begin
      for (int b = 0; b < 13; b++) begin
        issue(WID'(a), WID'(b), 8'd13);
        wait_res(edges, lows);
        exp_r = (a * b * 3) % 13;
        n_cmp++;
        if (res_vld !== 1'b1 || res_r !== WID'(exp_r) || res_r >= 8'd13) begin
          n_err++;
          $display("FAIL sweep13 a=%0d b=%0d: r=%0d vld=%b required r=%0d", a, b, res_r, res_vld, exp_r);
        end
        ack();
      end
    end
  endtask

  task automatic test_random();
    int edges, lows, m, a, b, exp_r;
    for (int i = 0; i < 40; i++) begin
      m = $urandom_range(3, 255) | 1;
      a = $urandom_range(0, m - 1);
      b = $urandom_range(0, m - 1);
      issue(WID'(a), WID'(b), WID'(m));
      wait_res(edges, lows);
      exp_r = mont_ref(a, b, m);
      n_cmp++;
      if (edges != WID + 2 || res_r !== WID'(exp_r) || res_err !== 1'b0) begin
        n_err++;
        $display("FAIL random a=%0d b=%0d m=%0d: r=%0d err=%b lat=%0d required r=%0d err=0 lat=%0d",
                 a, b, m, res_r, res_err, edges, exp_r, WID + 2);
      end
      ack();
    end
  endtask

  task automatic test_illegal();
    int edges, lows;
    logic [WID-1:0] ia [3];
    logic [WID-1:0] ib [3];
    logic [WID-1:0] im [3];
    ia[0] = 8'd5;  ib[0] = 8'd7;  im[0] = 8'd12;
    ia[1] = 8'd13; ib[1] = 8'd2;  im[1] = 8'd13;
    ia[2] = 8'd2;  ib[2] = 8'd20; im[2] = 8'd13;
    for (int i = 0; i < 3; i++) begin
      issue(ia[i], ib[i], im[i]);
      wait_res(edges, lows);
      // res_vld is registered on the accept edge. It is therefore already
      // high in the first cycle after accept, with no edges in between.
      n_cmp++;
      if (edges != 0 || lows != 0) begin
        n_err++; $display("FAIL illegal%0d_timing: lat=%0d ldnew_low=%0d required 0 and 0", i, edges, lows);
      end
      n_cmp++;
      if (res_err !== 1'b1 || res_r !== 8'd0 || mp_ldnew !== 1'b1) begin
        n_err++; $display("FAIL illegal%0d_result: err=%b r=%0d ldnew=%b required 1 0 1", i, res_err, res_r, mp_ldnew);
      end
      ack();
    end
    // The operand registers still hold the last legal request from the random test.
    n_cmp++;
    if (mp_m[0] !== 1'b1) begin n_err++; $display("FAIL illegal_operands: mp_m=%0d required odd", mp_m); end
  endtask

  task automatic test_hold_back_to_back();
    int edges, lows;
    issue(8'd5, 8'd7, 8'd13);
    wait_res(edges, lows);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({res_vld, res_err, req_rdy, busy} !== 4'b1001 || res_r !== 8'd1) begin
        n_err++;
        $display("FAIL hold%0d: vld/err/rdy/busy=%b r=%0d required 1001 r=1", i, {res_vld, res_err, req_rdy, busy}, res_r);
      end
    end
    ack();
    n_cmp++;
    if ({req_rdy, busy, res_vld} !== 3'b100) begin
      n_err++; $display("FAIL hold_release: rdy/busy/vld=%b required 100", {req_rdy, busy, res_vld});
    end
    // Back-to-back: accept on the edge right after the handshake.
    issue(8'd3, 8'd4, 8'd11);
    wait_res(edges, lows);
    n_cmp++;
    if (edges != WID + 2 || res_r !== WID'(mont_ref(3, 4, 11))) begin
      n_err++; $display("FAIL back_to_back: lat=%0d r=%0d required lat=%0d r=%0d", edges, res_r, WID + 2, mont_ref(3, 4, 11));
    end
    ack();
  endtask

  task automatic test_abort();
    int edges, lows;
    bit seen;
    issue(8'd5, 8'd7, 8'd13);
    repeat (4) @(negedge clk);           // RUN with counter = 3
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if ({req_rdy, busy, res_vld, res_err, mp_ldnew} !== 5'b10001) begin
      n_err++; $display("FAIL abort_run: rdy/busy/vld/err/ldnew=%b required 10001", {req_rdy, busy, res_vld, res_err, mp_ldnew});
    end
    n_cmp++;
    if (mp_a !== 8'd5 || mp_b !== 8'd7 || mp_m !== 8'd13) begin
      n_err++; $display("FAIL abort_operands: a=%0d b=%0d m=%0d required 5 7 13", mp_a, mp_b, mp_m);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (res_vld) seen = 1; end
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL abort_no_result: res_vld=1 required 0"); end
    // abort wins over an accept in IDLE.
    req_a = 8'd1; req_b = 8'd1; req_m = 8'd13; req_vld = 1'b1; abort = 1'b1;
    @(negedge clk);
    req_vld = 1'b0; abort = 1'b0;
    n_cmp++;
    if (req_rdy !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_vs_accept: rdy=%b busy=%b required 1 0", req_rdy, busy);
    end
    // abort wins over the result handshake in DONE.
    issue(8'd1, 8'd1, 8'd12);
    res_rdy = 1'b1; abort = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0; abort = 1'b0;
    n_cmp++;
    if ({res_vld, res_err, req_rdy} !== 3'b001) begin
      n_err++; $display("FAIL abort_done: vld/err/rdy=%b required 001", {res_vld, res_err, req_rdy});
    end
    issue(8'd5, 8'd7, 8'd13);
    wait_res(edges, lows);
    n_cmp++;
    if (edges != WID + 2 || res_r !== 8'd1) begin
      n_err++; $display("FAIL abort_recover: lat=%0d r=%0d required %0d 1", edges, res_r, WID + 2);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    int edges, lows;
    issue(8'd9, 8'd10, 8'd13);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({req_rdy, busy, res_vld, res_err, mp_ldnew} !== 5'b10001 || {mp_a, mp_b, mp_m, res_r} !== '0) begin
      n_err++; $display("FAIL reset_async: rdy/busy/vld/err/ldnew=%b a=%0d m=%0d required 10001 and zero regs",
                        {req_rdy, busy, res_vld, res_err, mp_ldnew}, mp_a, mp_m);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(8'd5, 8'd7, 8'd13);
    wait_res(edges, lows);
    n_cmp++;
    if (edges != WID + 2 || lows != WID || res_r !== 8'd1) begin
      n_err++; $display("FAIL reset_recover: lat=%0d low=%0d r=%0d required %0d %0d 1", edges, lows, res_r, WID + 2, WID);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_m255();
    test_sweep13();
    test_random();
    test_illegal();
    test_hold_back_to_back();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/montpro_seq.md
Name: montpro_seq

Overview:
- Sequencing controller for the bit-serial Montgomery multiplier datapath (montpro).
- Accepts one operand set (a, b, m) over a valid/ready handshake and holds the operands stable on the datapath.
- Issues the load pulse, counts exactly WID iteration cycles, and captures the datapath result in the single cycle it is valid.
- Applies the final conditional subtraction, returns the reduced result over a valid/ready handshake, and rejects illegal operand sets without running the datapath.

Parameters:
- WID, 256, operand width; must match the attached datapath.
- CW, 9, iteration counter width; must satisfy 2^CW > WID.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_vld  in  1  request valid
- req_rdy  out  1  request ready
- req_a  in  WID  multiplicand a
- req_b  in  WID  multiplier b
- req_m  in  WID  modulus m
- abort  in  1  synchronous cancel of any operation
- res_vld  out  1  result valid
- res_rdy  in  1  result accepted
- res_r  out  WID  result a*b*2^-WID mod m
- res_err  out  1  request rejected (qualified by res_vld)
- busy  out  1  high in every state except IDLE
- mp_a, mp_b, mp_m  out  WID each  operand registers driven to the datapath
- mp_ldnew  out  1  datapath load / clear
- mp_r  in  WID+1  datapath accumulator

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state = IDLE, counter = 0
  - operand registers = 0, result register = 0
  - res_vld = 0, res_err = 0, busy = 0
  - mp_ldnew = 1, req_rdy = 1 on release
- States: IDLE, LOAD, RUN, FIX, DONE.
- req_rdy = (state == IDLE). A request is accepted on the edge where req_vld && req_rdy && !abort.
- Legality check on the accept edge, using the request inputs:
  - illegal if m[0] == 0, or a >= m, or b >= m.
  - Legal: latch a/b/m into the operand registers and go to LOAD.
  - Illegal: go to DONE with res_err = 1 and res_r = 0; the operand registers are not updated.
- mp_ldnew = 1 in every state except RUN.
- LOAD: one cycle. The datapath loads the new operands and clears its accumulator. Go to RUN with counter = 0.
- RUN: counter increments each cycle. When counter == WID-1, go to FIX. This gives exactly WID iteration cycles.
- FIX: mp_r holds the final accumulator, and is valid only in this cycle.
  - Capture res_r = (mp_r >= {1'b0,m}) ? (mp_r - m) : mp_r, truncated to WID bits.
  - Comparison and subtraction are WID+1 bits wide.
  - Go to DONE with res_err = 0.
- DONE: res_vld = 1. res_r and res_err stay stable while res_rdy = 0. On res_vld && res_rdy, go to IDLE.
- Latency, counted from the accept edge:
  - legal request: res_vld rises WID+2 cycles later (LOAD 1 + RUN WID + FIX 1).
  - illegal request: res_vld rises 1 cycle later.
  - Back-to-back: a new request can be accepted one cycle after the result handshake.
- abort has priority over everything, including the accept and the result handshake. From any state, the next state is IDLE.
  - res_vld and res_err clear; the captured result is discarded.
  - The operand registers hold their values.
  - mp_ldnew = 1, so the datapath is cleared.
- Reset mid-operation has the same effect as abort, but is asynchronous and also zeroes all registers.
- No result is ever produced for an aborted or reset operation.
- The operand registers are held constant from LOAD through FIX. The datapath requires this.

Test Plan (WID=8, CW=4):
- m=13, a=5, b=7 -> accept; mp_ldnew low for exactly 8 cycles; res_vld rises 10 cycles after accept; res_r=1, res_err=0.
- m=255, a=254, b=254 -> res_r=1. Also sweep all a, b < 13 with m=13 against a model of a*b*9^-1 mod 13 (9^-1 ≡ 3) -> every result < 13 and matches the model.
- m=12 even -> res_vld one cycle after accept, res_err=1, res_r=0, mp_ldnew never drops. Repeat with a=13, m=13 -> same response.
- Legal request with res_rdy held low for 5 cycles in DONE -> res_vld, res_r and res_err stable; req_rdy=0; busy=1. res_rdy=1 -> IDLE next cycle.
- abort at RUN counter=3 -> IDLE next cycle, no res_vld, mp_ldnew=1. A following request m=13, a=5, b=7 -> res_r=1.
- rst pulsed low mid-RUN -> all outputs at reset values immediately (asynchronously). After release, a request completes normally with correct latency.
